// File: rtl/pico_loader.sv
`timescale 1ns/1ps
// pico_loader: framed byte stream -> 16-bit BRAM program writes, holds the sequencer during a load.
// Define PICO_LOADER_CHECKSUM_EN to add a trailing checksum byte and the sticky ERR flag.
module pico_loader #(
   parameter int          ADDR_WIDTH = 8,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
   input  logic                  CLKIN,
   input  logic                  RESET,
   input  logic [7:0]            DIN,
   input  logic                  DIN_VALID,
   output logic                  DIN_READY,
   output logic [ADDR_WIDTH-1:0] WADDR,
   output logic [15:0]           WDATA,
   output logic                  WE,
   output logic                  HOLD,
   output logic                  DONE,
   output logic                  ERR
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_GETADDR = 3'd1,
      S_GETCNT  = 3'd2,
      S_GETLO   = 3'd3,
      S_GETHI   = 3'd4,
      S_WRITE   = 3'd5,
      S_FINISH  = 3'd6
`ifdef PICO_LOADER_CHECKSUM_EN
      , S_GETCSUM = 3'd7
`endif
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [8:0]            cnt_q, cnt_d;
   logic [15:0]           wdata_q, wdata_d;
   logic                  hold_q, hold_d;
   logic                  take;

   // RESET gates READY combinationally so it reads 0 for the whole reset window.
   assign DIN_READY = !RESET && (state_q != S_WRITE) && (state_q != S_FINISH);
   assign take      = DIN_VALID && DIN_READY;
   assign WADDR     = ptr_q;
   assign WDATA     = wdata_q;
   assign WE        = (state_q == S_WRITE);
   assign DONE      = (state_q == S_FINISH);
   assign HOLD      = hold_q;

`ifdef PICO_LOADER_CHECKSUM_EN
   logic [7:0] acc_q, acc_d;
   logic       err_q, err_d;
   logic       csum_ok;

   assign ERR     = err_q;
   assign csum_ok = ((acc_q + DIN) == 8'd0);

   always_comb begin
      acc_d = acc_q;
      err_d = err_q;
      if (take) begin
         case (state_q)
            S_IDLE: if (DIN == SYNC_BYTE) begin
               acc_d = 8'd0;
               err_d = 1'b0;
            end
            S_GETADDR, S_GETCNT, S_GETLO, S_GETHI: acc_d = acc_q + DIN;
            S_GETCSUM: if (!csum_ok) err_d = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLKIN or posedge RESET) begin
      if (RESET) begin
         acc_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         err_q <= err_d;
      end
   end
`else
   assign ERR = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      wdata_d = wdata_q;
      hold_d  = hold_q;
      case (state_q)
         S_IDLE: if (take && DIN == SYNC_BYTE) begin
            state_d = S_GETADDR;
            hold_d  = 1'b1;
         end
         S_GETADDR: if (take) begin
            ptr_d   = ADDR_WIDTH'(DIN);
            state_d = S_GETCNT;
         end
         S_GETCNT: if (take) begin
            cnt_d   = (DIN == 8'd0) ? 9'd256 : {1'b0, DIN};
            state_d = S_GETLO;
         end
         S_GETLO: if (take) begin
            wdata_d[7:0] = DIN;
            state_d      = S_GETHI;
         end
         S_GETHI: if (take) begin
            wdata_d[15:8] = DIN;
            state_d       = S_WRITE;
         end
         S_WRITE: begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
            cnt_d = cnt_q - 9'd1;
            if (cnt_q != 9'd1) begin
               state_d = S_GETLO;
            end else begin
`ifdef PICO_LOADER_CHECKSUM_EN
               state_d = S_GETCSUM;
`else
               state_d = S_FINISH;
               hold_d  = 1'b0;
`endif
            end
         end
`ifdef PICO_LOADER_CHECKSUM_EN
         // A bad checksum leaves HOLD up so a partial program is never run.
         S_GETCSUM: if (take) begin
            if (csum_ok) begin
               state_d = S_FINISH;
               hold_d  = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
`endif
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLKIN or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cnt_q   <= 9'd0;
         wdata_q <= 16'd0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
      end
   end

endmodule

// File: tb/tb_pico_loader.sv
`timescale 1ns/1ps
// Self-checking bench for pico_loader: frame-level scoreboard plus cycle expectations from the frame rules.
module tb_pico_loader;

   localparam int T_DATA = 0, T_HI = 1, T_SYNC = 2, T_LASTHI = 3, T_CSUM_OK = 4, T_CSUM_BAD = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  din;
   logic        din_vld;
   logic        din_rdy;
   logic [7:0]  waddr;
   logic [15:0] wdata;
   logic        we, hold, done, err;

   always #5 clk = ~clk;

   pico_loader #(.ADDR_WIDTH(8), .SYNC_BYTE(8'hA5)) dut (
      .CLKIN(clk), .RESET(rst), .DIN(din), .DIN_VALID(din_vld), .DIN_READY(din_rdy),
      .WADDR(waddr), .WDATA(wdata), .WE(we), .HOLD(hold), .DONE(done), .ERR(err)
   );

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stimulus and expected-write queues
   logic [7:0]  bq[$];
   int          tq[$];
   logic [23:0] wq[$];
   logic [15:0] wd[$];
   int          cur_tag = T_DATA;

   task automatic queue_frame(input logic [7:0] a, input logic [7:0] c, input bit bad);
      int n;
      logic [7:0] sum, lo, hi, cs;
      logic [15:0] w;
      n = (c == 8'd0) ? 256 : int'(c);
      bq.push_back(8'hA5); tq.push_back(T_SYNC);
      bq.push_back(a);     tq.push_back(T_DATA);
      bq.push_back(c);     tq.push_back(T_DATA);
      sum = a + c;
      for (int k = 0; k < n; k++) begin
         if (wd.size() > 0) begin
            w = wd.pop_front();
            hi = w[15:8];
            lo = w[7:0];
         end else begin
            lo = 8'($urandom);
            hi = 8'($urandom);
         end
         bq.push_back(lo); tq.push_back(T_DATA);
         bq.push_back(hi); tq.push_back((k == n - 1) ? T_LASTHI : T_HI);
         sum = sum + lo + hi;
         wq.push_back({8'(int'(a) + k), hi, lo});
      end
`ifdef PICO_LOADER_CHECKSUM_EN
      cs = 8'd0 - sum;
      if (bad) cs = cs ^ 8'h01;
      bq.push_back(cs); tq.push_back(bad ? T_CSUM_BAD : T_CSUM_OK);
`else
      cs = sum;
      if (bad && cs == 8'hxx) $display("unreachable");
`endif
   endtask

   task automatic send_byte(input logic [7:0] b, input int tag);
      int  guard;
      bit  acc;
      guard = 0;
      acc   = 1'b0;
      while (!acc && guard < 200) begin
         @(negedge clk);
         din     = b;
         cur_tag = tag;
         din_vld = ($urandom_range(0, 2) != 0);
         #3;
         acc = din_vld && din_rdy;
         guard++;
      end
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_bytes(input int limit);
      int sent;
      sent = 0;
      while (bq.size() > 0 && sent < limit) begin
         send_byte(bq.pop_front(), tq.pop_front());
         sent++;
      end
      @(negedge clk);
      din_vld = 1'b0;
      cur_tag = T_DATA;
   endtask

   // Cycle expectations derived from the accepted-byte stream
   logic p_we = 0, p_done = 0, p_done2 = 0, e_hold = 0, e_err = 0;
   logic n_we, n_done, accm;
   logic [23:0] wexp;

   always begin
      @(negedge clk);
      #2;
      if (rst) begin
         p_we = 0; p_done = 0; p_done2 = 0; e_hold = 0; e_err = 0;
      end else begin
         check("we", we, p_we);
         check("done", done, p_done);
         check("hold", hold, e_hold);
         check("err", err, e_err);
         check("ready", din_rdy, !(p_we || p_done));
         if (we) begin
            if (wq.size() == 0) begin
               check("spurious_we", 32'd1, 32'd0);
            end else begin
               wexp = wq.pop_front();
               check("waddr", waddr, wexp[23:16]);
               check("wdata", wdata, wexp[15:0]);
            end
         end
         if (done) done_cnt++;
         accm = din_vld && din_rdy;
         n_we = accm && (cur_tag == T_HI || cur_tag == T_LASTHI);
`ifdef PICO_LOADER_CHECKSUM_EN
         n_done = accm && (cur_tag == T_CSUM_OK);
         if (accm && cur_tag == T_CSUM_BAD) e_err = 1;
`else
         n_done  = p_done2;
         p_done2 = accm && (cur_tag == T_LASTHI);
`endif
         if (accm && cur_tag == T_SYNC) begin
            e_hold = 1;
            e_err  = 0;
         end
         if (n_done) e_hold = 0;
         p_we   = n_we;
         p_done = n_done;
      end
   end

   typedef struct {
      logic [7:0] din;
      logic       vld;
      logic       exp_rdy;
      logic       exp_hold;
      logic       exp_we;
   } vec_t;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] cnt;
      bit         bad;
   } frame_t;

   task automatic finish_frame(input string name, input bit bad, input int d0);
      bit ebad;
`ifdef PICO_LOADER_CHECKSUM_EN
      ebad = bad;
`else
      ebad = 1'b0;
`endif
      repeat (4) @(negedge clk);
      #1;
      check({name, "_done"}, 32'(done_cnt - d0), ebad ? 32'd0 : 32'd1);
      check({name, "_writes_left"}, 32'(wq.size()), 32'd0);
      check({name, "_hold_end"}, hold, ebad);
      check({name, "_err_end"}, err, ebad);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t   vecs[5];
      frame_t frames[6];
      int     d0;

      vecs[0] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'hA4, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};

      frames[0] = '{8'h20, 8'h05, 1'b0};
      frames[1] = '{8'h10, 8'h02, 1'b1};
      frames[2] = '{8'h40, 8'h02, 1'b0};
      frames[3] = '{8'h00, 8'h00, 1'b0};
      frames[4] = '{8'hF0, 8'h20, 1'b0};
      frames[5] = '{8'h7F, 8'h01, 1'b0};

      rst = 1'b1; din = 8'h00; din_vld = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", din_rdy, 1'b0);
      check("rst_we", we, 1'b0);
      check("rst_waddr", waddr, 8'h00);
      check("rst_wdata", wdata, 16'h0000);
      check("rst_hold", hold, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #2;
      check("ready_after_rst", din_rdy, 1'b1);

      // Junk in IDLE is swallowed without effect
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         din = vecs[i].din; din_vld = vecs[i].vld; cur_tag = T_DATA;
         @(negedge clk);
         din_vld = 1'b0;
         #1;
         check($sformatf("idle_vec%0d_ready", i), din_rdy, vecs[i].exp_rdy);
         check($sformatf("idle_vec%0d_hold", i), hold, vecs[i].exp_hold);
         check($sformatf("idle_vec%0d_we", i), we, vecs[i].exp_we);
      end

      // Two-word frame with known data
      wd = '{16'h1234, 16'h70AB};
      d0 = done_cnt;
      queue_frame(8'h10, 8'h02, 1'b0);
      run_bytes(10000);
      finish_frame("t1", 1'b0, d0);

      // Address wrap 0xFF -> 0x00
      wd = '{16'h0001, 16'h0002};
      d0 = done_cnt;
      queue_frame(8'hFF, 8'h02, 1'b0);
      run_bytes(10000);
      finish_frame("wrap", 1'b0, d0);

      for (int f = 0; f < 6; f++) begin
         d0 = done_cnt;
         queue_frame(frames[f].addr, frames[f].cnt, frames[f].bad);
         run_bytes(10000);
         finish_frame($sformatf("frame%0d", f), frames[f].bad, d0);
      end

      // Reset in the middle of a frame
      wd = '{16'h1234, 16'h70AB};
      queue_frame(8'h10, 8'h02, 1'b0);
      run_bytes(4);
      rst = 1'b1;
      #1;
      check("midrst_hold", hold, 1'b0);
      check("midrst_we", we, 1'b0);
      check("midrst_ready", din_rdy, 1'b0);
      check("midrst_waddr", waddr, 8'h00);
      check("midrst_wdata", wdata, 16'h0000);
      check("midrst_done", done, 1'b0);
      bq.delete(); tq.delete(); wq.delete();
      repeat (3) @(negedge clk);
      #1;
      check("midrst_we_held", we, 1'b0);
      rst = 1'b0;
      d0 = done_cnt;
      queue_frame(8'h55, 8'h03, 1'b0);
      run_bytes(10000);
      finish_frame("after_rst", 1'b0, d0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
